// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - two-flop synchronised push-button debouncer with edge pulses and press counter
module debounce_sync #(
    parameter int STABLE_COUNT = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       level,
    output logic       rise,
    output logic       fall,
    output logic       busy,
    output logic [7:0] press_cnt
);
    typedef enum logic [1:0] {
        IDLE_LO,
        WAIT_HI,
        IDLE_HI,
        WAIT_LO
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t               state;
    logic                 s1;
    logic                 s2;
    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            state     <= IDLE_LO;
            cnt       <= '0;
            level     <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
            busy      <= 1'b0;
            press_cnt <= 8'd0;
        end else begin
            s1   <= btn_in;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                IDLE_LO: begin
                    if (s2) begin
                        state <= WAIT_HI;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end else begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                WAIT_HI: begin
                    // any low sample throws away the partial count
                    if (!s2) begin
                        state <= IDLE_LO;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE_HI;
                        cnt       <= '0;
                        busy      <= 1'b0;
                        level     <= 1'b1;
                        rise      <= 1'b1;
                        press_cnt <= press_cnt + 8'd1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                IDLE_HI: begin
                    if (!s2) begin
                        state <= WAIT_LO;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end else begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                WAIT_LO: begin
                    if (s2) begin
                        state <= IDLE_HI;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_LO;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        level <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE_LO;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - directed and randomized checks of debounce_sync against a run-length model
module tb_debounce_sync;
    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b0;
    logic       level, rise, fall, busy;
    logic [7:0] press_cnt;

    int total = 0;
    int bad   = 0;

    // model: input delay line, current level, length of the run of opposing samples
    logic       m_d1 = 1'b0, m_d2 = 1'b0;
    logic       m_level = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
    int         m_run = 0;
    logic [7:0] m_cnt = 8'd0;

    debounce_sync #(.STABLE_COUNT(SC), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .level(level), .rise(rise), .fall(fall), .busy(busy), .press_cnt(press_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic b, input logic r);
        logic seen;
        if (r) begin
            m_d1 = 0; m_d2 = 0; m_level = 0; m_rise = 0; m_fall = 0; m_run = 0; m_cnt = 0;
        end else begin
            seen   = m_d2;
            m_d2   = m_d1;
            m_d1   = b;
            m_rise = 0;
            m_fall = 0;
            if (seen != m_level) begin
                m_run++;
                if (m_run == SC) begin
                    m_level = seen;
                    m_run   = 0;
                    if (seen) begin
                        m_rise = 1;
                        m_cnt  = m_cnt + 8'd1;
                    end else begin
                        m_fall = 1;
                    end
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic step(input logic b, input logic r);
        @(negedge clk);
        btn_in = b;
        rst    = r;
        @(posedge clk);
        model_edge(b, r);
        #1;
        chk("level", 32'(level), 32'(m_level));
        chk("rise", 32'(rise), 32'(m_rise));
        chk("fall", 32'(fall), 32'(m_fall));
        chk("busy", 32'(busy), 32'(m_run > 0));
        chk("press_cnt", 32'(press_cnt), 32'(m_cnt));
        chk("rise_fall_excl", 32'(rise & fall), 32'd0);
    endtask

    int rise_at, fall_at, busy_n, rise_n, len;
    logic [7:0] cnt_before;
    logic bval;

    initial begin
        // reset state
        step(0, 1);
        step(0, 1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_cnt", 32'(press_cnt), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 0);

        // clean press
        rise_at = -1; busy_n = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 0);
            if (rise && rise_at < 0) rise_at = i;
            if (rise_at < 0) busy_n += int'(busy);
        end
        chk("press_rise_edge", 32'(rise_at), 32'd5);
        chk("press_busy_cycles", 32'(busy_n), 32'(SC - 1));
        chk("press_level", 32'(level), 32'd1);
        chk("press_cnt1", 32'(press_cnt), 32'd1);

        // release
        fall_at = -1;
        for (int i = 0; i < 10; i++) begin
            step(0, 0);
            if (fall && fall_at < 0) fall_at = i;
        end
        chk("release_fall_edge", 32'(fall_at), 32'd5);
        chk("release_level", 32'(level), 32'd0);
        chk("release_cnt", 32'(press_cnt), 32'd1);

        // bounce: 1,1,0 then held high; rise 5 edges after the last 0->1 sample
        rise_at = -1;
        for (int i = 0; i < 14; i++) begin
            step((i == 2) ? 1'b0 : 1'b1, 0);
            if (rise && rise_at < 0) rise_at = i;
        end
        chk("bounce_rise_edge", 32'(rise_at), 32'd8);
        for (int i = 0; i < 10; i++) step(0, 0);

        // glitch rejection: pulses of 1, 2 and 3 cycles
        cnt_before = press_cnt;
        rise_n = 0;
        for (int w = 1; w <= 3; w++) begin
            for (int i = 0; i < w; i++) begin step(1, 0); rise_n += int'(rise); end
            for (int i = 0; i < 8; i++) begin step(0, 0); rise_n += int'(rise); end
        end
        chk("glitch_no_rise", 32'(rise_n), 32'd0);
        chk("glitch_level", 32'(level), 32'd0);
        chk("glitch_cnt", 32'(press_cnt), 32'(cnt_before));

        // reset two cycles into WAIT_HI
        rise_n = 0;
        for (int i = 0; i < 4; i++) begin step(1, 0); rise_n += int'(rise); end
        chk("midq_busy", 32'(busy), 32'd1);
        step(1, 1);
        chk("midq_outputs", 32'({level, rise, fall, busy, press_cnt}), 32'd0);
        for (int i = 0; i < 8; i++) begin step(0, 0); rise_n += int'(rise); end
        chk("midq_no_rise", 32'(rise_n), 32'd0);

        // qualify right after reset with button held high
        step(1, 1);
        rise_at = -1;
        for (int i = 0; i < 8; i++) begin
            step(1, 0);
            if (rise && rise_at < 0) rise_at = i;
        end
        chk("post_rst_rise_edge", 32'(rise_at), 32'd5);
        chk("post_rst_level", 32'(level), 32'd1);

        // reset while level=1 clears level without fall
        step(1, 1);
        chk("rst_hi_level", 32'(level), 32'd0);
        chk("rst_hi_fall", 32'(fall), 32'd0);
        step(0, 1);

        // press counter wrap
        for (int p = 1; p <= 256; p++) begin
            for (int i = 0; i < SC + 3; i++) step(1, 0);
            for (int i = 0; i < SC + 3; i++) step(0, 0);
            if (p == 255) chk("wrap_255", 32'(press_cnt), 32'd255);
        end
        chk("wrap_0", 32'(press_cnt), 32'd0);

        // randomized runs with occasional reset
        for (int r = 0; r < 150; r++) begin
            bval = 1'($urandom_range(0, 1));
            len  = int'($urandom_range(1, 8));
            for (int i = 0; i < len; i++) step(bval, ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
